// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch datapath definitions: FSM encoding,
// sequential step and the word-alignment mask.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP_DFLT = 32'd4;
  localparam logic [31:0] ALIGN_MASK   = 32'h0000_0003;

  function automatic logic is_misaligned(
    input logic [31:0] a
  );
    return |(a & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle between
// the fetch unit (master) and instruction memory (slave).
interface pc_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC mux (branch target or PC+step, wrapping)
// plus the alignment check on the selected value.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] STEP = PC_STEP_DFLT
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] seq_pc;

  assign seq_pc = pc + STEP;

  always_comb begin
    next_pc = seq_pc;
    if (branch_taken) next_pc = branch_target;
    misaligned = is_misaligned(next_pc);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch:
// START -> FETCH -> DELIVER -> FETCH ..., FAULT on misalignment.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = PC_STEP_DFLT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             branch_target,
  input  logic                    branch_taken,
  input  logic                    stall,
  pc_fetch_unit_if.master         imem,
  output logic [31:0]             PC,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic                    misaligned_fault
);

  fetch_state_e state, state_nx;

  logic [31:0] pc_nx;
  logic        pc_mis;
  logic        req;
  logic        load;
  logic        consume;

  pc_next_sel #(
    .STEP(PC_STEP)
  ) u_sel (
    .pc            (PC),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (pc_nx),
    .misaligned    (pc_mis)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = PC;

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    load     = 1'b0;
    consume  = 1'b0;
    unique case (state)
      ST_START: state_nx = ST_FETCH;
      ST_FETCH: begin
        req = 1'b1;
        if (imem.imem_ready) begin
          load     = 1'b1;
          state_nx = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (!stall) begin
          consume  = 1'b1;
          state_nx = pc_mis ? ST_FAULT : ST_FETCH;
        end
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_START;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_START;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PC               <= RESET_PC;
      instr            <= 32'h0;
      instr_valid      <= 1'b0;
      misaligned_fault <= 1'b0;
    end else begin
      if (load) begin
        instr       <= imem.imem_rdata;
        instr_valid <= 1'b1;
      end
      if (consume) begin
        PC          <= pc_nx;
        instr_valid <= 1'b0;
        if (pc_mis) misaligned_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded directed bench for pc_fetch_unit,
// plus a second instance exercising PC wrap at 2^32.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] branch_target = 32'h0000_0200;
  logic        branch_taken  = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] PC, instr;
  logic        instr_valid, misaligned_fault;

  logic [31:0] pc2, instr2;
  logic        valid2, fault2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];
  logic        prev_valid = 1'b0;

  pc_fetch_unit_if ifm ();
  pc_fetch_unit_if ifw ();

  pc_fetch_unit dut (
    .clock            (clock),
    .reset            (reset),
    .branch_target    (branch_target),
    .branch_taken     (branch_taken),
    .stall            (stall),
    .imem             (ifm.master),
    .PC               (PC),
    .instr            (instr),
    .instr_valid      (instr_valid),
    .misaligned_fault (misaligned_fault)
  );

  pc_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC)
  ) dut_wrap (
    .clock            (clock),
    .reset            (reset),
    .branch_target    (32'h0000_0200),
    .branch_taken     (1'b0),
    .stall            (1'b0),
    .imem             (ifw.master),
    .PC               (pc2),
    .instr            (instr2),
    .instr_valid      (valid2),
    .misaligned_fault (fault2)
  );

  assign ifw.imem_ready = 1'b1;
  assign ifw.imem_rdata = 32'h0000_0013;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: one scoreboard entry per delivered instruction.
  always @(negedge clock) begin
    if (reset && instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected none",
                 PC, instr);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", PC, e[63:32]);
        chk("sb_instr", instr, e[31:0]);
      end
    end
    prev_valid = reset && instr_valid;
  end

  task automatic do_fetch(input logic [31:0] a);
    chk("fetch_req", {31'b0, ifm.imem_req}, 32'd1);
    chk("fetch_addr", ifm.imem_addr, a);
    ifm.imem_ready = 1'b1;
    ifm.imem_rdata = mem(a);
    sb_q.push_back({a, mem(a)});
    tick();
    ifm.imem_ready = 1'b0;
    ifm.imem_rdata = 32'h0;
    chk("deliver_valid", {31'b0, instr_valid}, 32'd1);
    chk("deliver_req", {31'b0, ifm.imem_req}, 32'd0);
  endtask

  task automatic do_consume(input logic bt, input logic [31:0] tgt,
                            input logic [31:0] exp_pc,
                            input logic exp_fault);
    stall = 1'b0;
    branch_taken = bt;
    branch_target = tgt;
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h0000_0200;
    chk("consume_pc", PC, exp_pc);
    chk("consume_addr", ifm.imem_addr, exp_pc);
    chk("consume_valid", {31'b0, instr_valid}, 32'd0);
    chk("consume_fault", {31'b0, misaligned_fault}, {31'b0, exp_fault});
    chk("consume_req", {31'b0, ifm.imem_req}, {31'b0, !exp_fault});
  endtask

  task automatic release_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("start_req", {31'b0, ifm.imem_req}, 32'd0);
    tick();
    chk("start_done_req", {31'b0, ifm.imem_req}, 32'd1);
    chk("start_done_addr", ifm.imem_addr, 32'h0);
  endtask

  initial begin
    ifm.imem_ready = 1'b0;
    ifm.imem_rdata = 32'h0;
    #2 reset = 1'b0;
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, ifm.imem_req}, 32'd0);
    chk("rst_fault", {31'b0, misaligned_fault}, 32'd0);
    release_reset();

    // Sequential stream 0,4,8
    do_fetch(32'h0);
    do_consume(1'b0, 32'h0000_0300, 32'h4, 1'b0);
    do_fetch(32'h4);
    do_consume(1'b0, 32'h0000_0300, 32'h8, 1'b0);
    do_fetch(32'h8);

    // Stall holds everything; branch inputs ignored
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, mem(32'h8));
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", PC, 32'h8);
      chk("stall_req", {31'b0, ifm.imem_req}, 32'd0);
    end
    do_consume(1'b1, 32'h0000_0040, 32'h40, 1'b0);

    // Memory not ready: request held, no timeout
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_req", {31'b0, ifm.imem_req}, 32'd1);
      chk("wait_addr", ifm.imem_addr, 32'h40);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    do_fetch(32'h40);
    do_consume(1'b1, 32'h0000_0040, 32'h40, 1'b0);
    do_fetch(32'h40);
    do_consume(1'b0, 32'h0000_0300, 32'h44, 1'b0);

    // Async reset mid-FETCH; late ready ignored
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midf_req", {31'b0, ifm.imem_req}, 32'd0);
    chk("midf_pc", PC, 32'h0);
    ifm.imem_ready = 1'b1;
    ifm.imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk("midf_late_valid", {31'b0, instr_valid}, 32'd0);
    chk("midf_late_instr", instr, 32'h0);
    ifm.imem_ready = 1'b0;
    release_reset();

    // Async reset mid-DELIVER drops the instruction
    do_fetch(32'h0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midd_valid", {31'b0, instr_valid}, 32'd0);
    chk("midd_instr", instr, 32'h0);
    release_reset();

    // Misaligned branch target -> terminal FAULT
    do_fetch(32'h0);
    do_consume(1'b1, 32'h0000_0042, 32'h42, 1'b1);
    ifm.imem_ready = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_req", {31'b0, ifm.imem_req}, 32'd0);
      chk("fault_valid", {31'b0, instr_valid}, 32'd0);
      chk("fault_pc", PC, 32'h42);
      chk("fault_flag", {31'b0, misaligned_fault}, 32'd1);
    end
    ifm.imem_ready = 1'b0;

    // Wrap instance: FFFF_FFFC + 4 -> 0, no fault
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
    chk("fault_cleared", {31'b0, misaligned_fault}, 32'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    tick();
    chk("wrap_fetch_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_fetch_req", {31'b0, ifw.imem_req}, 32'd1);
    tick();
    chk("wrap_valid", {31'b0, valid2}, 32'd1);
    tick();
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_fault", {31'b0, fault2}, 32'd0);
    chk("wrap_req", {31'b0, ifw.imem_req}, 32'd1);

    tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 32'd4: sequential increment.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port branch_target, input, 32: PC+immediate from the branch-target adder.
REQ-006 Port branch_taken, input, 1: select branch_target as next PC.
REQ-007 Port stall, input, 1: downstream not ready to accept the instruction.
REQ-008 Port imem_ready, input, 1: instruction memory has returned data this cycle.
REQ-009 Port imem_rdata, input, 32: instruction word from memory.
REQ-010 Port PC, output, 32: address of the current instruction; feeds the branch-target adder.
REQ-011 Port imem_req, output, 1: fetch request to instruction memory.
REQ-012 Port imem_addr, output, 32: fetch address, always equal to PC.
REQ-013 Port instr, output, 32: registered instruction word.
REQ-014 Port instr_valid, output, 1: instr holds a valid instruction for PC.
REQ-015 Port misaligned_fault, output, 1: sticky fault flag for a non-word-aligned next PC.

Function
REQ-016 The FSM SHALL have four states: START, FETCH, DELIVER and FAULT.
REQ-017 START SHALL last exactly one cycle after reset release and SHALL then go to FETCH, with imem_req=0.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC.
REQ-019 In FETCH, imem_ready=1 SHALL register imem_rdata into instr, set instr_valid=1 on the next edge and move to DELIVER.
REQ-020 In FETCH, imem_ready=0 SHALL hold the state; there is no timeout.
REQ-021 In DELIVER, imem_req SHALL be 0; instr, instr_valid and PC SHALL hold while stall=1.
REQ-022 In DELIVER, stall=0 consumes the instruction; on that edge next PC SHALL be branch_target if branch_taken=1, else PC+PC_STEP.
REQ-023 On that same edge, instr_valid SHALL be cleared and the FSM SHALL go to FETCH; the fetch-to-consume latency is one cycle after imem_ready.
REQ-024 branch_taken and branch_target SHALL be sampled only on the consume edge and ignored in every other state.
REQ-025 PC+PC_STEP SHALL wrap modulo 2^32; 32'hFFFF_FFFC steps to 32'h0000_0000 with no fault.
REQ-026 If the selected next PC has bits [1:0] != 0, PC SHALL still load it, misaligned_fault SHALL set and the FSM SHALL go to FAULT.
REQ-027 FAULT SHALL be terminal until reset: imem_req=0, instr_valid=0, PC frozen.
REQ-028 A branch_taken=1 with branch_target equal to PC SHALL be legal and SHALL refetch the same address.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock, force: PC=RESET_PC, instr=0, instr_valid=0, imem_req=0, misaligned_fault=0, FSM=START.
REQ-030 A reset asserted mid-FETCH or mid-DELIVER SHALL drop any outstanding request or instruction; a late imem_ready SHALL be ignored.
REQ-031 Release of reset SHALL take effect on the first rising clock edge after reset returns to 1.

Structure
REQ-032 The FSM state encoding, PC_STEP and the alignment mask SHALL be defined in the shared datapath package.
REQ-033 The next-PC selection and alignment check SHALL be one combinational sub-module, pc_next_sel; the FSM and registers stay in pc_fetch_unit.

Verification
REQ-034 Reset, then imem_ready=1 every FETCH cycle, stall=0, branch_taken=0 -> PC sequence 0,4,8,12; instr_valid pulses one cycle in every two.
REQ-035 In DELIVER at PC=8, stall=1 for 3 cycles, then 0 with branch_taken=1 and branch_target=0x40 -> instr held 3 cycles; next imem_addr=0x40.
REQ-036 imem_ready withheld 5 cycles in FETCH -> imem_req stays 1 with imem_addr constant; instr_valid stays 0.
REQ-037 Consume edge with branch_taken=1 and branch_target=0x42 -> PC=0x42, misaligned_fault=1, imem_req=0 permanently until reset.
REQ-038 RESET_PC=0xFFFF_FFFC, one sequential consume -> PC=0x0, no fault.
REQ-039 Reset asserted between clock edges mid-FETCH -> imem_req falls immediately; PC=RESET_PC; START lasts one cycle after release.
